// File: rtl/vp_pattern_gen_if.sv
// Video timing/pixel bundle between vp_pattern_gen and its consumer.
// pattern_sel exists only when VP_PATGEN_CHECKER_EN is defined.
interface vp_pattern_gen_if;
  logic        en;
`ifdef VP_PATGEN_CHECKER_EN
  logic        pattern_sel;
`endif
  logic        de_out;
  logic        h_sync_out;
  logic        v_sync_out;
  logic [23:0] pixel_out;
  logic        frame_start;

`ifdef VP_PATGEN_CHECKER_EN
  modport master (input en, input pattern_sel,
                  output de_out, output h_sync_out, output v_sync_out,
                  output pixel_out, output frame_start);
  modport slave  (output en, output pattern_sel,
                  input de_out, input h_sync_out, input v_sync_out,
                  input pixel_out, input frame_start);
`else
  modport master (input en,
                  output de_out, output h_sync_out, output v_sync_out,
                  output pixel_out, output frame_start);
  modport slave  (output en,
                  input de_out, input h_sync_out, input v_sync_out,
                  input pixel_out, input frame_start);
`endif
endinterface

// File: rtl/vp_pattern_gen.sv
// Free-running video timing + test pattern source (8 colour bars by default).
// Define VP_PATGEN_CHECKER_EN to add the checkerboard and the pattern_sel input.
module vp_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CHK_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  vp_pattern_gen_if.master vp
);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / 8);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [11:0] h_cnt, v_cnt;
  logic [11:0] bar_pos;
  logic [2:0]  bar_idx;
  logic        active, hs, vs, at_origin, at_end;
  logic [23:0] pix;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs        = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign vs        = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  assign at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
  assign at_end    = (h_cnt == H_LAST) && (v_cnt == V_LAST);

`ifdef VP_PATGEN_CHECKER_EN
  // The (0,0) pixel must already use the newly sampled selection.
  logic pat_q, pat_cur;
  assign pat_cur = at_origin ? vp.pattern_sel : pat_q;
  always_comb begin
    pix = bar_rgb(bar_idx);
    if (pat_cur)
      pix = (h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
  end
`else
  logic unused_chk_log2;
  assign unused_chk_log2 = ^12'(CHK_LOG2);
  always_comb pix = bar_rgb(bar_idx);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      h_cnt          <= '0;
      v_cnt          <= '0;
      bar_pos        <= '0;
      bar_idx        <= '0;
      vp.de_out      <= 1'b0;
      vp.h_sync_out  <= 1'b0;
      vp.v_sync_out  <= 1'b0;
      vp.pixel_out   <= '0;
      vp.frame_start <= 1'b0;
`ifdef VP_PATGEN_CHECKER_EN
      pat_q          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          vp.de_out      <= 1'b0;
          vp.h_sync_out  <= 1'b0;
          vp.v_sync_out  <= 1'b0;
          vp.pixel_out   <= '0;
          vp.frame_start <= 1'b0;
          if (vp.en) state <= RUN;
        end
        RUN: begin
          vp.de_out      <= active;
          vp.h_sync_out  <= hs;
          vp.v_sync_out  <= vs;
          vp.pixel_out   <= active ? pix : 24'h000000;
          vp.frame_start <= at_origin;
`ifdef VP_PATGEN_CHECKER_EN
          if (at_origin) pat_q <= vp.pattern_sel;
`endif
          // Counters wrap to (0,0) at frame end, which is also the IDLE hold value.
          if (h_cnt == H_LAST) begin
            h_cnt   <= '0;
            v_cnt   <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
            bar_pos <= '0;
            bar_idx <= '0;
          end else begin
            h_cnt <= h_cnt + 12'd1;
            if (bar_pos == BAR_W - 12'd1) begin
              bar_pos <= '0;
              if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
            end else begin
              bar_pos <= bar_pos + 12'd1;
            end
          end
          if (at_end && !vp.en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vp_pattern_gen.sv
// Randomized bench for vp_pattern_gen: every cycle is compared against a
// frame-position model that derives timing and colour with plain arithmetic.
module tb_vp_pattern_gen;
  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 4,  VF = 1, VSY = 1, VB = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam int BW = HA / 8;
  localparam int CL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vp_pattern_gen_if vif();

  vp_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .CHK_LOG2(CL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vp  (vif)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit          m_run = 1'b0;
  int          m_pos = 0;
  bit          m_pat = 1'b0;
  bit          sel   = 1'b0;
  logic        e_de, e_hs, e_vs, e_fs;
  logic [23:0] e_pix;
  logic [23:0] bars [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (pos %0d, t=%0t)", tag, obs, exp, m_pos, $time);
  endtask

  // Expected outputs for the frame position currently presented to the outputs.
  task automatic predict(input int pos, input bit pat);
    int h, v, b;
    h = pos % HT;
    v = pos / HT;
    e_de = (h < HA) && (v < VA);
    e_hs = (h >= HA + HF) && (h < HA + HF + HSY);
    e_vs = (v >= VA + VF) && (v < VA + VF + VSY);
    e_fs = (pos == 0);
    b = h / BW;
    if (b > 7) b = 7;
    if (!e_de)    e_pix = 24'h0;
    else if (pat) e_pix = (((h >> CL) + (v >> CL)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
    else          e_pix = bars[b];
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_run = 1'b0; m_pos = 0;
      {e_de, e_hs, e_vs, e_fs, e_pix} = '0;
    end else if (!m_run) begin
      {e_de, e_hs, e_vs, e_fs, e_pix} = '0;
      if (vif.en) begin m_run = 1'b1; m_pos = 0; end
    end else begin
`ifdef VP_PATGEN_CHECKER_EN
      if (m_pos == 0) m_pat = sel;
`endif
      predict(m_pos, m_pat);
      if (m_pos == FT - 1 && !vif.en) m_run = 1'b0;
      m_pos = (m_pos + 1) % FT;
    end
    @(negedge clk);
    chk("de_out",      {31'd0, vif.de_out},      {31'd0, e_de});
    chk("h_sync_out",  {31'd0, vif.h_sync_out},  {31'd0, e_hs});
    chk("v_sync_out",  {31'd0, vif.v_sync_out},  {31'd0, e_vs});
    chk("frame_start", {31'd0, vif.frame_start}, {31'd0, e_fs});
    chk("pixel_out",   {8'd0, vif.pixel_out},    {8'd0, e_pix});
  endtask

  task automatic run_until_pos(input int pos);
    for (int i = 0; i < 2 * FT && !(m_run && m_pos == pos); i++) cycle();
  endtask

`ifdef VP_PATGEN_CHECKER_EN
  assign vif.pattern_sel = sel;
`endif

  initial begin
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    vif.en = 1'b0;
    rst    = 1'b1;
    repeat (3) cycle();

    // start-up and two full frames of bars
    rst = 1'b0; vif.en = 1'b1;
    repeat (2 * FT + 10) cycle();

    // stop requested on line 1: frame completes, then silence
    run_until_pos(HT + 6);
    vif.en = 1'b0;
    repeat (FT + 40) cycle();

    // reset mid-frame at line 2, pixel 5 with en held high
    vif.en = 1'b1;
    run_until_pos(2 * HT + 5);
    rst = 1'b1; cycle();
    rst = 1'b0;
    repeat (FT + 20) cycle();

`ifdef VP_PATGEN_CHECKER_EN
    // checker frame, with a mid-frame toggle that must not take effect
    run_until_pos(FT - 3);
    sel = 1'b1;
    run_until_pos(40);
    sel = 1'b0;
    run_until_pos(FT - 1);
    sel = 1'b1;
    repeat (FT + 5) cycle();
`endif

    // random en / rst / pattern_sel traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) vif.en = ~vif.en;
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(19) == 0) sel = ~sel;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
